// File: rtl/riscv_alu_serdiv_param.sv
// riscv_alu_serdiv_param
// Iterative RISC-V divider for divu/div/remu/rem. It performs one restoring
// shift-subtract step per cycle on operand magnitudes. Leading zeros of the
// dividend are skipped, so an N-significant-bit dividend takes N steps.
// Division by zero, signed overflow and a zero dividend do not iterate;
// they go straight to the result state.
//
// Ports
//   Clk_CI      clock, rising edge
//   Rst_SI      synchronous active-high reset
//   OpA_DI      dividend
//   OpB_DI      divisor
//   OpCode_SI   0 divu, 1 div, 2 remu, 3 rem
//   InVld_SI    operands valid        InRdy_SO   ready to accept (IDLE)
//   Flush_SI    abort, back to IDLE
//   OutVld_SO   result valid (FINISH) OutRdy_SI  consumer takes result
//   Res_DO      quotient or remainder; in IDLE, the last result
//   DivZero_SO  result came from a zero divisor, qualified by OutVld_SO
//   Busy_SO     DIVIDE or FINISH
//
// state  | meaning
// IDLE   | waiting for operands, InRdy_SO high
// DIVIDE | one restoring step per cycle, r_cnt steps remaining
// FINISH | result presented until OutRdy_SI
module riscv_alu_serdiv_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk_CI,
  input  logic             Rst_SI,
  input  logic [WIDTH-1:0] OpA_DI,
  input  logic [WIDTH-1:0] OpB_DI,
  input  logic [1:0]       OpCode_SI,
  input  logic             InVld_SI,
  output logic             InRdy_SO,
  input  logic             Flush_SI,
  output logic             OutVld_SO,
  input  logic             OutRdy_SI,
  output logic [WIDTH-1:0] Res_DO,
  output logic             DivZero_SO,
  output logic             Busy_SO
);

  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("riscv_alu_serdiv_param: WIDTH must be within 8..64");
  end
  if (CNT_W != $clog2(WIDTH + 1)) begin : g_bad_cnt_w
    $error("riscv_alu_serdiv_param: CNT_W must equal $clog2(WIDTH+1)");
  end

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_rem_sel;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_divzero;

  // Operand decode, only meaningful in the acceptance cycle
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [CNT_W-1:0] w_lzc;
  logic [CNT_W-1:0] w_n;
  logic             w_b_zero;
  logic             w_a_zero;
  logic             w_ovf;
  logic             w_special;
  logic [WIDTH-1:0] w_special_res;
  logic             w_accept;

  assign w_signed = OpCode_SI[0];
  assign w_a_neg  = w_signed & OpA_DI[WIDTH-1];
  assign w_b_neg  = w_signed & OpB_DI[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -OpA_DI : OpA_DI;
  assign w_b_mag  = w_b_neg ? -OpB_DI : OpB_DI;
  assign w_b_zero = (OpB_DI == '0);
  assign w_a_zero = (OpA_DI == '0);
  assign w_ovf    = w_signed & (OpA_DI == MIN_VAL) & (&OpB_DI);
  assign w_special = w_b_zero | w_a_zero | w_ovf;
  assign w_accept = InVld_SI & (r_state == S_IDLE);

  // Leading-zero count of |A|; the highest set bit wins because it is visited last
  always_comb begin
    w_lzc = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (w_a_mag[i]) w_lzc = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign w_n = CNT_W'(WIDTH) - w_lzc;

  // Zero divisor takes priority, so 0/0 yields the divide-by-zero results
  always_comb begin
    w_special_res = '0;
    if (w_b_zero)   w_special_res = OpCode_SI[1] ? OpA_DI : '1;
    else if (w_ovf) w_special_res = OpCode_SI[1] ? '0 : MIN_VAL;
  end

  // One restoring step: shift the next dividend bit into the partial remainder
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_res_fin;

  assign w_trial   = {r_rem, r_q[WIDTH-1]};
  assign w_diff    = w_trial - {1'b0, r_b};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_q_nxt   = {r_q[WIDTH-2:0], w_ge};
  assign w_res_fin = r_rem_sel ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                               : (r_neg_q ? -w_q_nxt   : w_q_nxt);

  always_ff @(posedge Clk_CI) begin
    if (Rst_SI) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_rem_sel <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_divzero <= 1'b0;
    end else if (Flush_SI) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem_sel <= OpCode_SI[1];
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_b       <= w_b_mag;
            r_rem     <= '0;
            // Left-align the dividend so its MSB is consumed on the first step
            r_q       <= w_a_mag << w_lzc;
            r_divzero <= w_b_zero;
            if (w_special) begin
              r_res   <= w_special_res;
              r_cnt   <= '0;
              r_state <= S_FINISH;
            end else begin
              r_cnt   <= w_n;
              r_state <= S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_res   <= w_res_fin;
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (OutRdy_SI) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign InRdy_SO   = (r_state == S_IDLE);
  assign OutVld_SO  = (r_state == S_FINISH);
  assign Busy_SO    = (r_state == S_DIVIDE) | (r_state == S_FINISH);
  assign Res_DO     = r_res;
  assign DivZero_SO = r_divzero & (r_state == S_FINISH);

endmodule

// File: tb/tb_riscv_alu_serdiv_param.sv
module tb_riscv_alu_serdiv_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [1:0]  opcode = '0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic        flush = 1'b0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [31:0] res;
  logic        div_zero;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  riscv_alu_serdiv_param #(.WIDTH(32)) dut (
    .Clk_CI(clk), .Rst_SI(rst), .OpA_DI(op_a), .OpB_DI(op_b),
    .OpCode_SI(opcode), .InVld_SI(in_vld), .InRdy_SO(in_rdy),
    .Flush_SI(flush), .OutVld_SO(out_vld), .OutRdy_SI(out_rdy),
    .Res_DO(res), .DivZero_SO(div_zero), .Busy_SO(busy)
  );

  always #5 clk = ~clk;

  // Presents operands for one edge, then scrambles them so a design that
  // samples outside the acceptance cycle produces a wrong answer.
  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    opcode = op; op_a = a; op_b = b; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    op_a = $urandom; op_b = $urandom; opcode = 2'($urandom_range(0, 3));
  endtask

  // Counts cycles after the acceptance edge until OutVld_SO, bounded.
  task automatic wait_out(output int lat);
    lat = 1;
    while (out_vld !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic dz, output int lat);
    accept(op, a, b);
    wait_out(lat);
    r = res; dz = div_zero;
    handshake();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    n_total++; if (in_rdy !== 1'b1) $display("FAIL reset_inrdy got %b want 1", in_rdy); else n_pass++;
    n_total++; if (out_vld !== 1'b0) $display("FAIL reset_outvld got %b want 0", out_vld); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (div_zero !== 1'b0) $display("FAIL reset_divzero got %b want 0", div_zero); else n_pass++;
    n_total++; if (res !== 32'h0) $display("FAIL reset_res got %h want 0", res); else n_pass++;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        dz;
    int          lat;
    string       name;
  } vec_t;

  task automatic run_vectors(input vec_t v[$]);
    logic [31:0] r; logic dz; int lat;
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, r, dz, lat);
      n_total++;
      if (r !== v[i].exp) $display("FAIL %s_res got %h want %h", v[i].name, r, v[i].exp); else n_pass++;
      n_total++;
      if (dz !== v[i].dz) $display("FAIL %s_dz got %b want %b", v[i].name, dz, v[i].dz); else n_pass++;
      n_total++;
      if (lat != v[i].lat) $display("FAIL %s_lat got %0d want %0d", v[i].name, lat, v[i].lat); else n_pass++;
    end
  endtask

  task automatic test_divide();
    vec_t v[$];
    v.push_back('{2'd1, 32'd20,        32'd3,        32'd6,          1'b0, 6,  "div_20_3"});
    v.push_back('{2'd3, 32'd20,        32'd3,        32'd2,          1'b0, 6,  "rem_20_3"});
    v.push_back('{2'd3, 32'hFFFFFFEC,  32'd3,        32'hFFFFFFFE,   1'b0, 6,  "rem_m20_3"});
    v.push_back('{2'd1, 32'hFFFFFFEC,  32'd3,        32'hFFFFFFFA,   1'b0, 6,  "div_m20_3"});
    v.push_back('{2'd1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD,   1'b0, 4,  "div_7_m2"});
    v.push_back('{2'd3, 32'd7,         32'hFFFFFFFE, 32'd1,          1'b0, 4,  "rem_7_m2"});
    v.push_back('{2'd0, 32'hFFFFFFFF,  32'd3,        32'h55555555,   1'b0, 33, "divu_max_3"});
    v.push_back('{2'd2, 32'd100,       32'd7,        32'd2,          1'b0, 8,  "remu_100_7"});
    run_vectors(v);
  endtask

  task automatic test_special();
    vec_t v[$];
    v.push_back('{2'd0, 32'd7,         32'd0,        32'hFFFFFFFF,   1'b1, 1, "divu_7_0"});
    v.push_back('{2'd2, 32'd7,         32'd0,        32'd7,          1'b1, 1, "remu_7_0"});
    v.push_back('{2'd3, 32'hFFFFFFFB,  32'd0,        32'hFFFFFFFB,   1'b1, 1, "rem_m5_0"});
    v.push_back('{2'd1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000,   1'b0, 1, "div_ovf"});
    v.push_back('{2'd3, 32'h80000000,  32'hFFFFFFFF, 32'd0,          1'b0, 1, "rem_ovf"});
    v.push_back('{2'd0, 32'd0,         32'd5,        32'd0,          1'b0, 1, "divu_0_5"});
    run_vectors(v);
  endtask

  task automatic test_flush();
    int seen = 0;
    logic [31:0] r; logic dz; int lat;
    accept(2'd0, 32'hFFFFFFFF, 32'd3);
    repeat (2) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_total++; if (in_rdy !== 1'b1) $display("FAIL flush_inrdy got %b want 1", in_rdy); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      if (out_vld === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_total++; if (seen != 0) $display("FAIL flush_outvld got %0d valid cycles want 0", seen); else n_pass++;
    // Flush held with a valid request: nothing may be accepted
    opcode = 2'd0; op_a = 32'd9; op_b = 32'd3; in_vld = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_vld = 1'b0; flush = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL flush_over_vld got busy %b want 0", busy); else n_pass++;
    do_op(2'd0, 32'd100, 32'd7, r, dz, lat);
    n_total++; if (r !== 32'd14) $display("FAIL after_flush_res got %h want %h", r, 32'd14); else n_pass++;
    n_total++; if (lat != 8) $display("FAIL after_flush_lat got %0d want 8", lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; int bad = 0; int rdy_bad = 0;
    accept(2'd0, 32'd1000, 32'd10);
    wait_out(lat);
    n_total++; if (lat != 11) $display("FAIL hold_lat got %0d want 11", lat); else n_pass++;
    // Stall the consumer while hammering the input side
    for (int i = 0; i < 5; i++) begin
      opcode = 2'd0; op_a = $urandom; op_b = 32'd1; in_vld = 1'b1;
      @(posedge clk); #1;
      if (res !== 32'd100 || out_vld !== 1'b1) bad++;
      if (in_rdy !== 1'b0) rdy_bad++;
    end
    n_total++; if (bad != 0) $display("FAIL hold_stable got %0d bad cycles want 0", bad); else n_pass++;
    n_total++; if (rdy_bad != 0) $display("FAIL hold_inrdy got %0d bad cycles want 0", rdy_bad); else n_pass++;
    // Handshake edge with InVld still high: must not accept in the same edge
    opcode = 2'd0; op_a = 32'd9; op_b = 32'd3; in_vld = 1'b1; out_rdy = 1'b1;
    @(posedge clk); #1; out_rdy = 1'b0;
    n_total++; if (in_rdy !== 1'b1 || busy !== 1'b0) $display("FAIL no_turnaround got inrdy %b busy %b want 1 0", in_rdy, busy); else n_pass++;
    n_total++; if (res !== 32'd100) $display("FAIL idle_hold_res got %h want %h", res, 32'd100); else n_pass++;
    @(posedge clk); #1;
    in_vld = 1'b0; op_a = $urandom; op_b = $urandom;
    wait_out(lat);
    n_total++; if (res !== 32'd3) $display("FAIL b2b_res got %h want %h", res, 32'd3); else n_pass++;
    n_total++; if (lat != 5) $display("FAIL b2b_lat got %0d want 5", lat); else n_pass++;
    handshake();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    accept(2'd0, 32'hFFFFFFFF, 32'd3);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; flush = 1'b1; in_vld = 1'b1; op_a = 32'd9; op_b = 32'd3;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; in_vld = 1'b0;
    n_total++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0 || busy !== 1'b0 || div_zero !== 1'b0 || res !== 32'h0)
      $display("FAIL rst_mid got rdy %b vld %b busy %b dz %b res %h want 1 0 0 0 0",
               in_rdy, out_vld, busy, div_zero, res);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      if (out_vld === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_total++; if (seen != 0) $display("FAIL rst_mid_outvld got %0d valid cycles want 0", seen); else n_pass++;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_divide();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule
